// File: rtl/wr_router_1_4_32bits.sv
// rtl/wr_router_1_4_32bits.sv - 1-to-4 write router with 2-entry FIFO
// Head request is presented to exactly one destination, chosen by In_Addr[SEL_LSB+1:SEL_LSB].
module wr_router_1_4_32bits #(
  parameter int SEL_LSB = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] In_Addr,
  input  logic [31:0] In_Data,
  output logic [3:0]  Out_Valid,
  input  logic [3:0]  Out_Ready,
  output logic [31:0] Out_Addr,
  output logic [31:0] Out_Data,
  output logic [1:0]  Count
);

  logic [31:0] addr_q [2];
  logic [31:0] data_q [2];
  logic [1:0]  sel_q  [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic [1:0]  head_sel;
  logic        push;
  logic        pop;

  assign head_sel = sel_q[rd_ptr_q];

  // Only the selected destination's ready may retire the head; reset cycles never pop.
  assign pop      = !reset && (count_q != 2'd0) && Out_Ready[head_sel];
  assign In_Ready = (count_q != 2'd2) || pop;
  assign push     = In_Valid && In_Ready;

  assign Out_Valid = (count_q != 2'd0) ? (4'b0001 << head_sel) : 4'b0000;
  assign Out_Addr  = addr_q[rd_ptr_q];
  assign Out_Data  = data_q[rd_ptr_q];
  assign Count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; it is only observed while Count != 0.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      addr_q[wr_ptr_q] <= In_Addr;
      data_q[wr_ptr_q] <= In_Data;
      sel_q[wr_ptr_q]  <= In_Addr[SEL_LSB+1:SEL_LSB];
    end
  end

endmodule

// File: tb/tb_wr_router_1_4_32bits.sv
// tb/tb_wr_router_1_4_32bits.sv - self-checking bench for wr_router_1_4_32bits
module tb_wr_router_1_4_32bits;

  logic        clk = 1'b0;
  logic        reset;
  logic        In_Valid;
  logic        In_Ready;
  logic [31:0] In_Addr;
  logic [31:0] In_Data;
  logic [3:0]  Out_Valid;
  logic [3:0]  Out_Ready;
  logic [31:0] Out_Addr;
  logic [31:0] Out_Data;
  logic [1:0]  Count;

  int n_checks = 0;
  int n_fail   = 0;

  wr_router_1_4_32bits #(.SEL_LSB(8)) dut (
    .clk(clk), .reset(reset),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Addr(In_Addr), .In_Data(In_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Addr(Out_Addr), .Out_Data(Out_Data),
    .Count(Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t model_q[$];
  bit   model_live = 1'b0;

  function automatic int sel_of(logic [31:0] a);
    return int'(a[9:8]);
  endfunction

  function automatic bit model_pop();
    if (model_q.size() == 0) return 1'b0;
    return Out_Ready[sel_of(model_q[0].a)];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO queue updated at each edge from the presented handshakes.
  always @(posedge clk) begin
    if (reset) begin
      model_q.delete();
      model_live <= 1'b1;
    end else if (model_live) begin
      bit p, s;
      ent_t e;
      p = model_pop();
      s = In_Valid && ((model_q.size() < 2) || p);
      e.a = In_Addr;
      e.d = In_Data;
      if (p) void'(model_q.pop_front());
      if (s) model_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (model_live && !reset) begin
      chk("model_count", {30'd0, Count}, model_q.size());
      chk("model_in_ready", {31'd0, In_Ready}, {31'd0, (model_q.size() < 2) || model_pop()});
      if (model_q.size() != 0) begin
        chk("model_out_valid", {28'd0, Out_Valid}, 32'd1 << sel_of(model_q[0].a));
        chk("model_out_addr", Out_Addr, model_q[0].a);
        chk("model_out_data", Out_Data, model_q[0].d);
      end else begin
        chk("model_out_valid_idle", {28'd0, Out_Valid}, 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    In_Valid  = 1'b0;
    Out_Ready = 4'b1111;
    repeat (3) cyc();
  endtask

  initial begin
    reset = 1'b1; In_Valid = 1'b0; In_Addr = '0; In_Data = '0; Out_Ready = '0;
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_count", {30'd0, Count}, 32'd0);
    chk("reset_out_valid", {28'd0, Out_Valid}, 32'd0);
    chk("reset_in_ready", {31'd0, In_Ready}, 32'd1);
    cyc();

    // Single request to destination 1
    In_Valid = 1'b1; In_Addr = 32'h0000_0100; In_Data = 32'hDEAD_BEEF; Out_Ready = 4'b0010;
    cyc();
    In_Valid = 1'b0;
    @(negedge clk);
    chk("single_valid", {28'd0, Out_Valid}, 32'h2);
    chk("single_data", Out_Data, 32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    chk("single_count_after", {30'd0, Count}, 32'd0);
    chk("single_valid_after", {28'd0, Out_Valid}, 32'd0);
    cyc();

    // Routing sweep
    Out_Ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      In_Valid = 1'b1; In_Addr = 32'(i) << 8; In_Data = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      chk("sweep_in_ready", {31'd0, In_Ready}, 32'd1);
      if (i > 0) chk("sweep_valid", {28'd0, Out_Valid}, 32'd1 << (i - 1));
      cyc();
    end
    In_Valid = 1'b0;
    @(negedge clk);
    chk("sweep_valid_last", {28'd0, Out_Valid}, 32'h8);
    drain();

    // Full and backpressure
    Out_Ready = 4'b0000;
    In_Valid = 1'b1; In_Addr = 32'h000; In_Data = 32'h1111_0000; cyc();
    In_Addr = 32'h100; In_Data = 32'h1111_0001; cyc();
    In_Addr = 32'h200; In_Data = 32'h1111_0002;
    @(negedge clk);
    chk("full_count", {30'd0, Count}, 32'd2);
    chk("full_in_ready", {31'd0, In_Ready}, 32'd0);
    cyc();
    Out_Ready = 4'b0001;
    @(negedge clk);
    chk("full_pop_in_ready", {31'd0, In_Ready}, 32'd1);
    cyc();
    In_Valid = 1'b0; Out_Ready = 4'b0000;
    @(negedge clk);
    chk("full_count_kept", {30'd0, Count}, 32'd2);
    chk("full_next_head", {28'd0, Out_Valid}, 32'h2);
    chk("full_next_data", Out_Data, 32'h1111_0001);
    drain();

    // Head-of-line blocking
    Out_Ready = 4'b0001;
    In_Valid = 1'b1; In_Addr = 32'h200; In_Data = 32'h2222_0002; cyc();
    In_Addr = 32'h000; In_Data = 32'h2222_0000; cyc();
    In_Valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hol_blocked_valid", {28'd0, Out_Valid}, 32'h4);
      chk("hol_blocked_count", {30'd0, Count}, 32'd2);
      cyc();
    end
    Out_Ready = 4'b0100;
    cyc();
    @(negedge clk);
    chk("hol_second_valid", {28'd0, Out_Valid}, 32'h1);
    chk("hol_second_data", Out_Data, 32'h2222_0000);
    drain();

    // Wrong-port ready ignored
    Out_Ready = 4'b0000;
    In_Valid = 1'b1; In_Addr = 32'h300; In_Data = 32'h3333_0003; cyc();
    In_Valid = 1'b0; Out_Ready = 4'b0111;
    repeat (5) begin
      cyc();
      @(negedge clk);
      chk("wrong_port_count", {30'd0, Count}, 32'd1);
      chk("wrong_port_valid", {28'd0, Out_Valid}, 32'h8);
    end
    drain();

    // Mid-operation reset
    Out_Ready = 4'b0000;
    In_Valid = 1'b1; In_Addr = 32'h100; In_Data = 32'h4444_0001; cyc();
    In_Addr = 32'h300; In_Data = 32'h4444_0003; cyc();
    In_Valid = 1'b0;
    @(negedge clk);
    chk("prereset_count", {30'd0, Count}, 32'd2);
    reset = 1'b1; cyc(); reset = 1'b0;
    @(negedge clk);
    chk("midreset_count", {30'd0, Count}, 32'd0);
    chk("midreset_valid", {28'd0, Out_Valid}, 32'd0);
    chk("midreset_in_ready", {31'd0, In_Ready}, 32'd1);
    In_Valid = 1'b1; In_Addr = 32'h200; In_Data = 32'h1234_5678; cyc();
    In_Valid = 1'b0;
    @(negedge clk);
    chk("postreset_valid", {28'd0, Out_Valid}, 32'h4);
    chk("postreset_data", Out_Data, 32'h1234_5678);
    chk("postreset_count", {30'd0, Count}, 32'd1);
    drain();

    // Randomized traffic against the queue model
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 249) == 0);
      In_Valid  = ($urandom_range(0, 3) != 0);
      In_Addr   = $urandom;
      In_Data   = $urandom;
      Out_Ready = 4'($urandom_range(0, 15));
      cyc();
    end
    reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
